// File: rtl/buzzer_tone_gen.sv
// -----------------------------------------------------------------------------
// buzzer_tone_gen
//
// Square-wave tone generator for the piano buzzer. A key index 1..15 selects a
// pitch from C4 to C6 (half-period table defined for a 100 MHz clock). Pitch
// changes are only applied at half-period boundaries so a sounding tone never
// produces a runt pulse; stopping or muting cuts the tone on the next cycle.
//
// Parameters:
//   SIM_SHIFT      right-shift applied to every half-period count (simulation
//                  speed-up); each shifted count is clamped to at least 1.
//
// Ports:
//   clk            system clock (100 MHz)
//   rst            synchronous, active-high reset
//   key_on_i       request to sound key_i
//   key_i[3:0]     note index, 0 = rest, 1..15 = C4..C6
//   mute_i         global mute, silences the output on the next cycle
//   buzzer_o       registered square-wave drive to the buzzer
//   tone_active_o  registered, high while a tone is sounding (RUN state)
//   cur_key_o[3:0] registered, key currently being sounded (0 when idle)
// -----------------------------------------------------------------------------
module buzzer_tone_gen #(
    parameter int SIM_SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_on_i,
    input  logic [3:0] key_i,
    input  logic       mute_i,
    output logic       buzzer_o,
    output logic       tone_active_o,
    output logic [3:0] cur_key_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Raw half-period in clk cycles at 100 MHz for each key.
    function automatic logic [17:0] half_raw(input logic [3:0] k);
        logic [17:0] h;
        case (k)
            4'd1:    h = 18'd191113;
            4'd2:    h = 18'd170265;
            4'd3:    h = 18'd151685;
            4'd4:    h = 18'd143172;
            4'd5:    h = 18'd127551;
            4'd6:    h = 18'd113636;
            4'd7:    h = 18'd101238;
            4'd8:    h = 18'd95556;
            4'd9:    h = 18'd85131;
            4'd10:   h = 18'd75843;
            4'd11:   h = 18'd71586;
            4'd12:   h = 18'd63776;
            4'd13:   h = 18'd56818;
            4'd14:   h = 18'd50619;
            4'd15:   h = 18'd47778;
            default: h = 18'd0;
        endcase
        return h;
    endfunction

    // Counter reload value: the effective half-period minus one, since the
    // counter spends one cycle at each value down to and including zero.
    function automatic logic [17:0] reload_val(input logic [3:0] k);
        logic [17:0] h;
        h = half_raw(k) >> SIM_SHIFT;
        if (h == 18'd0) begin
            h = 18'd1;
        end else begin
            h = h;
        end
        return h - 18'd1;
    endfunction

    logic [0:0]  state_q,  state_d;
    logic        buzzer_q, buzzer_d;
    logic [3:0]  cur_key_q, cur_key_d;
    logic [17:0] cnt_q,    cnt_d;
    logic        start_s;

    assign start_s = key_on_i && (key_i != 4'd0) && !mute_i;

    // Next-state logic for the IDLE/RUN machine, half-period counter and outputs.
    always_comb begin
        state_d   = state_q;
        buzzer_d  = buzzer_q;
        cur_key_d = cur_key_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d   = ST_RUN;
                    buzzer_d  = 1'b1;
                    cur_key_d = key_i;
                    cnt_d     = reload_val(key_i);
                end else begin
                    state_d   = ST_IDLE;
                    buzzer_d  = 1'b0;
                    cur_key_d = 4'd0;
                    cnt_d     = 18'd0;
                end
            end
            ST_RUN: begin
                if (!start_s) begin
                    // Stop wins over everything: cut the tone regardless of phase.
                    state_d   = ST_IDLE;
                    buzzer_d  = 1'b0;
                    cur_key_d = 4'd0;
                    cnt_d     = 18'd0;
                end else if (cnt_q == 18'd0) begin
                    // Half-period boundary: the only place a new pitch is taken.
                    buzzer_d  = ~buzzer_q;
                    cur_key_d = key_i;
                    cnt_d     = reload_val(key_i);
                end else begin
                    cnt_d     = cnt_q - 18'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                buzzer_d  = 1'b0;
                cur_key_d = 4'd0;
                cnt_d     = 18'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            buzzer_q  <= 1'b0;
            cur_key_q <= 4'd0;
            cnt_q     <= 18'd0;
        end else begin
            state_q   <= state_d;
            buzzer_q  <= buzzer_d;
            cur_key_q <= cur_key_d;
            cnt_q     <= cnt_d;
        end
    end

    assign buzzer_o      = buzzer_q;
    assign tone_active_o = (state_q == ST_RUN);
    assign cur_key_o     = cur_key_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_buzzer_tone_gen
//
// Two instances share one stimulus: SIM_SHIFT=10 (real table scaled down) and
// SIM_SHIFT=17 (every pitch clamps to a half-period of 1). A reference model
// describes the tone as "level plus cycles remaining in the current
// half-period" and is compared with both instances every cycle; directed
// literal expectations pin phase lengths and latencies.
// -----------------------------------------------------------------------------
module tb_buzzer_tone_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_on = 1'b0;
    logic [3:0] key = 4'd0;
    logic       mute = 1'b0;

    logic       buz_a, act_a;
    logic [3:0] ck_a;
    logic       buz_b, act_b;
    logic [3:0] ck_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    buzzer_tone_gen #(.SIM_SHIFT(10)) dut_s10 (
        .clk(clk), .rst(rst), .key_on_i(key_on), .key_i(key), .mute_i(mute),
        .buzzer_o(buz_a), .tone_active_o(act_a), .cur_key_o(ck_a)
    );

    buzzer_tone_gen #(.SIM_SHIFT(17)) dut_s17 (
        .clk(clk), .rst(rst), .key_on_i(key_on), .key_i(key), .mute_i(mute),
        .buzzer_o(buz_b), .tone_active_o(act_b), .cur_key_o(ck_b)
    );

    typedef struct packed {
        logic        active;
        logic        buzz;
        logic [3:0]  key;
        logic [31:0] rem;   // cycles left in the current half-period
    } model_t;

    model_t m_a, m_b;

    // Half-period in cycles for key k after scaling, never below one cycle.
    function automatic int h_of(input logic [3:0] k, input int shift);
        int tbl [16];
        int t;
        tbl = '{0, 191113, 170265, 151685, 143172, 127551, 113636, 101238,
                95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};
        t = tbl[k] >> shift;
        if (t < 1) t = 1;
        return t;
    endfunction

    // One clock of the tone behaviour given the inputs sampled at that edge.
    function automatic model_t step(input model_t m, input logic r, input logic on,
                                    input logic [3:0] k, input logic mu, input int shift);
        model_t n;
        n = m;
        if (r || !(on && k != 4'd0 && !mu)) begin
            n = '0;
        end else if (!m.active) begin
            n.active = 1'b1;
            n.buzz   = 1'b1;
            n.key    = k;
            n.rem    = h_of(k, shift);
        end else begin
            n.rem = m.rem - 1;
            if (n.rem == 0) begin
                n.buzz = ~m.buzz;
                n.key  = k;
                n.rem  = h_of(k, shift);
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    endtask

    // Advance one clock: step the model with the current inputs, then compare
    // both instances against it on the falling edge.
    task automatic tick();
        model_t na, nb;
        na = step(m_a, rst, key_on, key, mute, 10);
        nb = step(m_b, rst, key_on, key, mute, 17);
        @(posedge clk);
        m_a = na;
        m_b = nb;
        @(negedge clk);
        cyc++;
        chk("model_s10", int'({buz_a, act_a, ck_a}), int'({m_a.buzz, m_a.active, m_a.key}));
        chk("model_s17", int'({buz_b, act_b, ck_b}), int'({m_b.buzz, m_b.active, m_b.key}));
    endtask

    // Count consecutive samples (including the current one) at the given level.
    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (buz_a == lvl && n < 5000) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int w;
        m_a = '0;
        m_b = '0;

        // Reset held while a key is requested.
        rst = 1'b1; key_on = 1'b1; key = 4'd6;
        tick();
        tick();
        chk("rst_buzzer", int'(buz_a), 0);
        chk("rst_active", int'(act_a), 0);
        chk("rst_curkey", int'(ck_a), 0);
        rst = 1'b0;
        tick();
        chk("start_buzzer", int'(buz_a), 1);
        chk("start_curkey", int'(ck_a), 6);

        // Key 6 at shift 10: 113636>>10 = 110 cycles per half-period.
        measure(1'b1, n); chk("k6_high", n, 110);
        measure(1'b0, n); chk("k6_low", n, 110);
        measure(1'b1, n); chk("k6_high2", n, 110);

        // Glitch-free change: key 1 (186) -> 15 (46) on cycle 50 of a high phase.
        key_on = 1'b0;
        tick();
        chk("stop_buzzer", int'(buz_a), 0);
        key_on = 1'b1; key = 4'd1;
        tick();
        chk("restart_buzzer", int'(buz_a), 1);
        n = 0;
        while (buz_a == 1'b1 && n < 5000) begin
            n++;
            if (n == 50) key = 4'd15;
            if (n == 100) chk("hold_curkey", int'(ck_a), 1);
            tick();
        end
        chk("glitch_high", n, 186);
        chk("glitch_curkey", int'(ck_a), 15);
        measure(1'b0, n); chk("k15_low", n, 46);
        measure(1'b1, n); chk("k15_high", n, 46);

        // Single-cycle mute cuts the tone, then it restarts with a fresh count.
        tick();
        mute = 1'b1;
        tick();
        chk("mute_buzzer", int'(buz_a), 0);
        chk("mute_active", int'(act_a), 0);
        mute = 1'b0;
        tick();
        chk("unmute_buzzer", int'(buz_a), 1);
        measure(1'b1, n); chk("unmute_high", n, 46);

        // Rest key keeps both instances idle.
        key = 4'd0;
        repeat (5) tick();
        chk("rest_active_s10", int'(act_a), 0);
        chk("rest_active_s17", int'(act_b), 0);

        // Clamped half-period of 1: toggles every cycle starting high.
        key = 4'd15;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("clamp_toggle", int'(buz_b), (i % 2 == 0) ? 1 : 0);
            tick();
        end

        // Reset at an arbitrary point of a running tone.
        key = 4'd9;
        w = $urandom_range(150, 5);
        repeat (w) tick();
        rst = 1'b1;
        tick();
        chk("midrst_out", int'({buz_a, act_a, ck_a, buz_b, act_b, ck_b}), 0);
        rst = 1'b0;
        tick();
        chk("midrst_restart", int'(buz_a), 1);

        // Randomized stimulus, checked every cycle against the model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(63, 0) == 0) key = 4'($urandom_range(15, 0));
            if ($urandom_range(49, 0) == 0) key_on = ~key_on;
            mute = ($urandom_range(199, 0) == 0);
            rst  = ($urandom_range(499, 0) == 0);
            tick();
        end
        rst = 1'b0;
        mute = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
